ram_sp_init: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request interface, registered read data, bit-masked writes and a hardware clear engine. The clear engine fills every word with a fixed value after reset and on command. This block supersedes the fixed 64x8 storage cell as the general on-chip scratch memory. It sits between a bus/control master and local datapath logic.

---
 rtl/ram_sp_init_if.sv | 30 +++
 rtl/ram_sp_init.sv | 118 +++++++++++
 tb/tb_ram_sp_init.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_init_if.sv
// Request/response bundle for ram_sp_init: valid/ready request channel,
// registered read response, clear command and busy status.
interface ram_sp_init_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  // Requester side: issues commands, observes handshake and responses.
  modport master (
    output clear, req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  // Memory side.
  modport slave (
    input  clear, req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/ram_sp_init.sv
// ram_sp_init: single-port synchronous RAM with a valid/ready request port,
// bit-masked writes, one-cycle registered reads and a clear engine that
// fills every word with INIT_VAL after reset and on a clear command.
module ram_sp_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic          clk,
  input logic          rst_n,
  ram_sp_init_if.slave bus
);
  // Storage index is only as wide as DEPTH needs; addresses above DEPTH-1
  // are filtered by in_range before any array access matters.
  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              busy;
  logic              accept;
  logic              in_range;
  logic              rd_en;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign accept   = bus.req_valid & ready;
  assign rd_en    = accept & ~bus.req_write;
  assign wr_en    = accept & bus.req_write & in_range;

  // State and sweep counter; reset always restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep runs to the last word then hands over; clear only counts in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.clear) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and busy flags decode the registered state only.
  always_comb begin
    ready = (state_q == ST_READY);
    busy  = (state_q == ST_INIT);
  end

  // Array write port: sweep fill in INIT, masked read-modify-write in READY.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_en) begin
      mem[idx] <= (mem[idx] & ~bus.req_wmask) | (bus.req_wdata & bus.req_wmask);
    end
  end

  // Read response: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      rsp_err_q   <= rd_en & ~in_range;
      if (rd_en) begin
        rsp_rdata_q <= in_range ? mem[idx] : '0;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.init_busy = busy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ram_sp_init.sv
// Directed plus randomized bench for ram_sp_init: a full-depth instance
// (64 words) and a partial-depth instance (48 words) checked against a
// plain array model of the memory contents.
module tb_ram_sp_init;
  localparam logic [7:0] INIT_A  = 8'h5A;
  localparam logic [7:0] INIT_B  = 8'hC3;
  localparam int         DEPTH_A = 64;
  localparam int         DEPTH_B = 48;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_sp_init_if #(.DATA_W(8), .ADDR_W(6)) bus_a ();
  ram_sp_init_if #(.DATA_W(8), .ADDR_W(6)) bus_b ();

  ram_sp_init #(.DATA_W(8), .ADDR_W(6), .DEPTH(DEPTH_A), .INIT_VAL(INIT_A)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  ram_sp_init #(.DATA_W(8), .ADDR_W(6), .DEPTH(DEPTH_B), .INIT_VAL(INIT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  logic [7:0] mdl_a [DEPTH_A];
  logic [7:0] mdl_b [DEPTH_B];
  logic [7:0] last_a = 8'h00;
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.req_valid = 1'b0; bus_a.clear = 1'b0; bus_a.req_write = 1'b0;
    bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.req_wmask = '0;
  endtask

  task automatic idle_b();
    bus_b.req_valid = 1'b0; bus_b.clear = 1'b0; bus_b.req_write = 1'b0;
    bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.req_wmask = '0;
  endtask

  // One accepted request on instance A; inputs stay driven for streaming.
  task automatic req_a(input bit wr, input int addr, input logic [7:0] wd,
                       input logic [7:0] wm, input bit clr, input string tag);
    logic [7:0] exp;
    check({tag, "_rdy"}, 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid = 1'b1; bus_a.req_write = wr; bus_a.req_addr = 6'(addr);
    bus_a.req_wdata = wd; bus_a.req_wmask = wm; bus_a.clear = clr;
    tick();
    if (wr) begin
      mdl_a[addr] = (mdl_a[addr] & ~wm) | (wd & wm);
      check({tag, "_noresp"}, 32'(bus_a.rsp_valid), 32'd0);
      $display("A %s wr addr=%0d data=%02h mask=%02h", tag, addr, wd, wm);
    end else begin
      exp = mdl_a[addr];
      check({tag, "_vld"}, 32'(bus_a.rsp_valid), 32'd1);
      check({tag, "_data"}, 32'(bus_a.rsp_rdata), 32'(exp));
      check({tag, "_err"}, 32'(bus_a.rsp_err), 32'd0);
      last_a = exp;
      $display("A %s rd addr=%0d data=%02h exp=%02h", tag, addr, bus_a.rsp_rdata, exp);
    end
  endtask

  // One accepted request on instance B, where addresses >= 48 are out of range.
  task automatic req_b(input bit wr, input int addr, input logic [7:0] wd,
                       input logic [7:0] wm, input string tag);
    logic [7:0] exp;
    check({tag, "_rdy"}, 32'(bus_b.req_ready), 32'd1);
    bus_b.req_valid = 1'b1; bus_b.req_write = wr; bus_b.req_addr = 6'(addr);
    bus_b.req_wdata = wd; bus_b.req_wmask = wm;
    tick();
    if (wr) begin
      if (addr < DEPTH_B) mdl_b[addr] = (mdl_b[addr] & ~wm) | (wd & wm);
      check({tag, "_noresp"}, 32'(bus_b.rsp_valid), 32'd0);
      $display("B %s wr addr=%0d data=%02h mask=%02h", tag, addr, wd, wm);
    end else begin
      exp = (addr < DEPTH_B) ? mdl_b[addr] : 8'h00;
      check({tag, "_vld"}, 32'(bus_b.rsp_valid), 32'd1);
      check({tag, "_data"}, 32'(bus_b.rsp_rdata), 32'(exp));
      check({tag, "_err"}, 32'(bus_b.rsp_err), (addr >= DEPTH_B) ? 32'd1 : 32'd0);
      $display("B %s rd addr=%0d data=%02h err=%0b", tag, addr, bus_b.rsp_rdata, bus_b.rsp_err);
    end
    idle_b();
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_a_rdy"},  32'(bus_a.req_ready), 32'd0);
    check({tag, "_a_busy"}, 32'(bus_a.init_busy), 32'd1);
    check({tag, "_a_vld"},  32'(bus_a.rsp_valid), 32'd0);
    check({tag, "_a_err"},  32'(bus_a.rsp_err),   32'd0);
    check({tag, "_a_data"}, 32'(bus_a.rsp_rdata), 32'd0);
    check({tag, "_b_rdy"},  32'(bus_b.req_ready), 32'd0);
    check({tag, "_b_busy"}, 32'(bus_b.init_busy), 32'd1);
    check({tag, "_b_vld"},  32'(bus_b.rsp_valid), 32'd0);
    check({tag, "_b_data"}, 32'(bus_b.rsp_rdata), 32'd0);
    $display("reset check %s", tag);
  endtask

  // Count edges until ready rises; optionally pulse clear mid-sweep and hold
  // a write request on A while it is busy (neither may have any effect).
  task automatic sweep(input string tag, input bit do_b, input int clr_at, input bit poke);
    int na;
    int nb;
    int stray;
    na = -1; nb = do_b ? -1 : 0; stray = 0;
    if (poke) begin
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = 6'd7;
      bus_a.req_wdata = 8'hFF; bus_a.req_wmask = 8'hFF;
    end
    for (int n = 1; n <= 200 && (na < 0 || nb < 0); n++) begin
      bus_a.clear = (n == clr_at);
      tick();
      if (na < 0 && bus_a.rsp_valid !== 1'b0) stray++;
      if (na < 0 && bus_a.req_ready === 1'b1) na = n;
      if (nb < 0 && bus_b.req_ready === 1'b1) nb = n;
    end
    idle_a();
    check({tag, "_a_len"}, 32'(na), 32'(DEPTH_A));
    check({tag, "_a_stray"}, 32'(stray), 32'd0);
    check({tag, "_a_busy"}, 32'(bus_a.init_busy), 32'd0);
    for (int i = 0; i < DEPTH_A; i++) mdl_a[i] = INIT_A;
    if (do_b) begin
      check({tag, "_b_len"}, 32'(nb), 32'(DEPTH_B));
      check({tag, "_b_busy"}, 32'(bus_b.init_busy), 32'd0);
      for (int i = 0; i < DEPTH_B; i++) mdl_b[i] = INIT_B;
    end
    $display("sweep %s a=%0d b=%0d", tag, na, nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ad;
    bit w;
    idle_a();
    idle_b();
    rst_n = 1'b0;
    repeat (3) tick();
    chk_rst("por");
    rst_n = 1'b1;
    sweep("por", 1'b1, -1, 1'b0);

    // Basic read, full write, masked write, zero-mask write.
    req_a(1'b0, 5, 8'h00, 8'h00, 1'b0, "rd5");
    req_a(1'b1, 3, 8'hA5, 8'hFF, 1'b0, "wr3");
    req_a(1'b0, 3, 8'h00, 8'h00, 1'b0, "rd3a");
    req_a(1'b1, 3, 8'h3C, 8'h0F, 1'b0, "mwr3");
    req_a(1'b0, 3, 8'h00, 8'h00, 1'b0, "rd3b");
    req_a(1'b1, 3, 8'h00, 8'h00, 1'b0, "nomask3");
    req_a(1'b0, 3, 8'h00, 8'h00, 1'b0, "rd3c");
    idle_a();
    tick();
    check("hold_vld", 32'(bus_a.rsp_valid), 32'd0);
    check("hold_data", 32'(bus_a.rsp_rdata), 32'(last_a));

    // Streaming writes then streaming reads, one per cycle.
    for (int i = 0; i < DEPTH_A; i++) req_a(1'b1, i, 8'(i), 8'hFF, 1'b0, "swr");
    for (int i = 0; i < DEPTH_A; i++) req_a(1'b0, i, 8'h00, 8'h00, 1'b0, "srd");

    // Randomized mix against the model.
    for (int i = 0; i < 150; i++) begin
      ad = int'($urandom_range(0, DEPTH_A - 1));
      w  = 1'($urandom_range(0, 1));
      req_a(w, ad, 8'($urandom), 8'($urandom), 1'b0, "rnd");
    end

    // Clear together with a read: read completes, then a full sweep.
    req_a(1'b1, 3, 8'hAC, 8'hFF, 1'b0, "preclr");
    req_a(1'b0, 3, 8'h00, 8'h00, 1'b1, "clrrd3");
    idle_a();
    check("clr_rdy_low", 32'(bus_a.req_ready), 32'd0);
    check("clr_busy", 32'(bus_a.init_busy), 32'd1);
    sweep("clr", 1'b0, 10, 1'b1);
    req_a(1'b0, 7, 8'h00, 8'h00, 1'b0, "pclr7");
    req_a(1'b0, 3, 8'h00, 8'h00, 1'b0, "pclr3");
    req_a(1'b0, 63, 8'h00, 8'h00, 1'b0, "pclr63");
    req_a(1'b0, int'($urandom_range(0, 62)), 8'h00, 8'h00, 1'b0, "pclrr");
    idle_a();

    // Partial-depth instance: out-of-range handling and last word.
    req_b(1'b1, 50, 8'hFF, 8'hFF, "b_wr50");
    req_b(1'b0, 50, 8'h00, 8'h00, "b_rd50");
    req_b(1'b0, 47, 8'h00, 8'h00, "b_rd47");
    req_b(1'b0, 2, 8'h00, 8'h00, "b_rd2");
    req_b(1'b0, 18, 8'h00, 8'h00, "b_rd18");
    req_b(1'b1, 47, 8'h12, 8'hF0, "b_mwr47");
    req_b(1'b0, 47, 8'h00, 8'h00, "b_rd47m");
    req_b(1'b0, 63, 8'h00, 8'h00, "b_rd63");

    // Reset in the middle of a sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk_rst("rst_sweep");
    repeat (2) tick();
    chk_rst("rst_sweep_hold");
    rst_n = 1'b1;
    sweep("rst_sweep", 1'b1, -1, 1'b0);

    // Reset with a read response outstanding and a request still asserted.
    req_a(1'b1, 9, 8'h77, 8'hFF, 1'b0, "prerst9");
    req_a(1'b0, 9, 8'h00, 8'h00, 1'b0, "rdrst9");
    req_b(1'b0, 47, 8'h00, 8'h00, "b_rdrst");
    rst_n = 1'b0;
    #1;
    chk_rst("rst_read");
    repeat (2) tick();
    chk_rst("rst_read_hold");
    idle_a();
    rst_n = 1'b1;
    sweep("rst_read", 1'b1, -1, 1'b0);
    req_a(1'b0, 9, 8'h00, 8'h00, 1'b0, "final9");
    req_b(1'b0, 47, 8'h00, 8'h00, "b_final47");
    idle_a();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
